conv_frame_sequencer: RTL

//  Frame-level scheduler for the 3x3 convolution datapath. Walks every output pixel in raster order.
//  For each pixel it: fetches the 3x3 window from the padded image RAM, feeding the window shift register;

---
 rtl/conv_frame_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/conv_frame_sequencer.sv
// Raster-order frame scheduler for the 3x3 convolution datapath: fetches each padded
// window, runs the conv unit through a start/done handshake and writes the result out.
module conv_frame_sequencer #(
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128,
  parameter int ADDR_W     = 15,
  parameter int OUT_ADDR_W = 14,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic                  win_shift,
  output logic                  conv_start,
  input  logic                  conv_done,
  input  logic [DATA_W-1:0]     conv_result,
  output logic                  wr_en,
  output logic [OUT_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int PW    = IMG_W + 2;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, CONV, WRITE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [3:0]              k_q, k_d;
  logic [1:0]              k_row, k_col;
  logic                    last_pixel;

  logic                    rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  logic                    win_shift_q, win_shift_d;
  logic                    conv_start_q, conv_start_d;
  logic                    wr_en_q, wr_en_d;
  logic [OUT_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]       wr_data_q, wr_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  assign last_pixel = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));

  // Next state and counters
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    k_d       = k_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = FETCH;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
        end
      end
      FETCH: begin
        if (k_q == 4'd8) state_d = DRAIN;
        else             k_d     = k_q + 4'd1;
      end
      DRAIN: state_d = CONV;
      CONV: begin
        // conv_start_q marks the first CONV cycle, where conv_done is not yet honoured
        if (!conv_start_q && conv_done && !abort) begin
          state_d   = WRITE;
          wr_data_d = conv_result;
        end
      end
      WRITE: begin
        k_d = '0;
        if (last_pixel) begin
          state_d = DONE;
        end else begin
          state_d = FETCH;
          if (col_q < COL_W'(IMG_W - 1)) begin
            col_d = col_q + COL_W'(1);
          end else begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  always_comb begin
    k_row = 2'd0;
    k_col = 2'd0;
    case (k_d)
      4'd1: k_col = 2'd1;
      4'd2: k_col = 2'd2;
      4'd3: k_row = 2'd1;
      4'd4: begin k_row = 2'd1; k_col = 2'd1; end
      4'd5: begin k_row = 2'd1; k_col = 2'd2; end
      4'd6: k_row = 2'd2;
      4'd7: begin k_row = 2'd2; k_col = 2'd1; end
      4'd8: begin k_row = 2'd2; k_col = 2'd2; end
      default: ;
    endcase
  end

  // Outputs are registered from the next state so every strobe lines up with its state
  always_comb begin
    rd_en_d      = (state_d == FETCH);
    rd_addr_d    = rd_addr_q;
    if (state_d == FETCH) begin
      rd_addr_d = (ADDR_W'(row_d) + ADDR_W'(k_row)) * ADDR_W'(PW)
                + ADDR_W'(col_d) + ADDR_W'(k_col);
    end
    win_shift_d  = ((state_d == FETCH) && (k_d != 4'd0)) || (state_d == DRAIN);
    conv_start_d = (state_d == CONV) && (state_q != CONV);
    wr_en_d      = (state_d == WRITE);
    wr_addr_d    = wr_addr_q;
    if (state_d == WRITE) begin
      wr_addr_d = OUT_ADDR_W'(row_q) * OUT_ADDR_W'(IMG_W) + OUT_ADDR_W'(col_q);
    end
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      k_q          <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      win_shift_q  <= 1'b0;
      conv_start_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      k_q          <= k_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      win_shift_q  <= win_shift_d;
      conv_start_q <= conv_start_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign win_shift  = win_shift_q;
  assign conv_start = conv_start_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
